// File: rtl/dcu_txn_trk.sv
// Load-transaction tracker: pairs DCU load returns with their issuing addresses per source
// and raises sticky protocol errors. Issue counters are built only when DCU_TRK_STATS_EN is defined.
module dcu_txn_trk #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [7:0]  iu_inst_c,
  input  logic [3:0]  smu_inst_c,
  input  logic [31:0] dcu_addr_c,
  input  logic [31:0] dcu_data,
  input  logic        iu_data_vld,
  input  logic        smu_data_vld,
  output logic        trk_iu_vld,
  output logic        trk_smu_vld,
  output logic [31:0] trk_iu_addr,
  output logic [31:0] trk_smu_addr,
  output logic [31:0] trk_data,
  output logic [4:0]  trk_iu_outst,
  output logic [4:0]  trk_smu_outst,
  output logic [3:0]  trk_err,
  output logic [31:0] trk_ld_cnt,
  output logic [31:0] trk_st_cnt
);

  localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL = 5'(DEPTH);
  localparam logic [15:0] TO  = 16'(TIMEOUT);

  // Index 0 is the IU source, index 1 the SMU source.
  logic [31:0]   mem_q [2][DEPTH];
  logic [PW-1:0] wp_q [2], wp_d [2];
  logic [PW-1:0] rp_q [2], rp_d [2];
  logic [4:0]    cnt_q [2], cnt_d [2];
  logic [15:0]   age_q [2], age_d [2];
  logic [31:0]   head [2];
  logic [1:0]    push, vld, pop, orphan, ovf, wr_en, tmo;

  logic [1:0]    vld_q;
  logic [31:0]   iu_addr_q, smu_addr_q, data_q;
  logic [3:0]    err_q;

  always_comb begin
    push   = {smu_inst_c[0], iu_inst_c[2]};
    vld    = {smu_data_vld, iu_data_vld};
    pop    = '0;
    orphan = '0;
    ovf    = '0;
    wr_en  = '0;
    tmo    = '0;
    for (int s = 0; s < 2; s++) begin
      // Occupancy is judged before this cycle's push, so a return never pairs with a same-cycle push.
      pop[s]    = vld[s] && (cnt_q[s] != 5'd0);
      orphan[s] = vld[s] && (cnt_q[s] == 5'd0);
      ovf[s]    = push[s] && (cnt_q[s] == FULL) && !pop[s];
      wr_en[s]  = push[s] && !ovf[s];
      head[s]   = mem_q[s][rp_q[s]];
      wp_d[s]   = wr_en[s] ? wp_q[s] + PW'(1) : wp_q[s];
      rp_d[s]   = pop[s]   ? rp_q[s] + PW'(1) : rp_q[s];
      cnt_d[s]  = cnt_q[s] + {4'd0, wr_en[s]} - {4'd0, pop[s]};
      if (pop[s] || (cnt_q[s] == 5'd0))
        age_d[s] = 16'd0;
      else if (age_q[s] != 16'hFFFF)
        age_d[s] = age_q[s] + 16'd1;
      else
        age_d[s] = age_q[s];
      tmo[s] = (age_d[s] == TO);
    end
  end

  // FIFO storage carries no reset; a full-FIFO push+pop overwrites the slot being read, which is safe
  // because the head is captured on the same edge.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (wr_en[s]) mem_q[s][wp_q[s]] <= dcu_addr_c;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
        age_q[s] <= '0;
      end
      vld_q      <= '0;
      iu_addr_q  <= '0;
      smu_addr_q <= '0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= wp_d[s];
        rp_q[s]  <= rp_d[s];
        cnt_q[s] <= cnt_d[s];
        age_q[s] <= age_d[s];
      end
      vld_q <= pop;
      if (pop[0]) iu_addr_q  <= head[0];
      if (pop[1]) smu_addr_q <= head[1];
      if (|pop)   data_q     <= dcu_data;
      err_q <= err_q | {|tmo, vld[0] & vld[1], |orphan, |ovf};
    end
  end

  assign trk_iu_vld    = vld_q[0];
  assign trk_smu_vld   = vld_q[1];
  assign trk_iu_addr   = iu_addr_q;
  assign trk_smu_addr  = smu_addr_q;
  assign trk_data      = data_q;
  assign trk_iu_outst  = cnt_q[0];
  assign trk_smu_outst = cnt_q[1];
  assign trk_err       = err_q;

`ifdef DCU_TRK_STATS_EN
  logic [31:0] ld_cnt_q, st_cnt_d, ld_cnt_d, st_cnt_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_comb begin
    ld_cnt_d = sat_add(ld_cnt_q, {1'b0, iu_inst_c[2]} + {1'b0, smu_inst_c[0]});
    st_cnt_d = sat_add(st_cnt_q, {1'b0, iu_inst_c[3]} + {1'b0, smu_inst_c[1]});
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign trk_ld_cnt = ld_cnt_q;
  assign trk_st_cnt = st_cnt_q;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{iu_inst_c[7:4], iu_inst_c[1:0], smu_inst_c[3:2]};
`else
  assign trk_ld_cnt = 32'd0;
  assign trk_st_cnt = 32'd0;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{iu_inst_c[7:3], iu_inst_c[1:0], smu_inst_c[3:1]};
`endif

endmodule

// File: tb/tb_dcu_txn_trk.sv
// Directed bench for dcu_txn_trk: queue model of both FIFOs, scoreboard of expected completions.
module tb_dcu_txn_trk;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [7:0]  iu_inst_c;
  logic [3:0]  smu_inst_c;
  logic [31:0] dcu_addr_c, dcu_data;
  logic        iu_data_vld, smu_data_vld;
  logic        trk_iu_vld, trk_smu_vld;
  logic [31:0] trk_iu_addr, trk_smu_addr, trk_data;
  logic [4:0]  trk_iu_outst, trk_smu_outst;
  logic [3:0]  trk_err;
  logic [31:0] trk_ld_cnt, trk_st_cnt;

  always #5 clk = ~clk;

  dcu_txn_trk #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_l(reset_l),
    .iu_inst_c(iu_inst_c), .smu_inst_c(smu_inst_c),
    .dcu_addr_c(dcu_addr_c), .dcu_data(dcu_data),
    .iu_data_vld(iu_data_vld), .smu_data_vld(smu_data_vld),
    .trk_iu_vld(trk_iu_vld), .trk_smu_vld(trk_smu_vld),
    .trk_iu_addr(trk_iu_addr), .trk_smu_addr(trk_smu_addr), .trk_data(trk_data),
    .trk_iu_outst(trk_iu_outst), .trk_smu_outst(trk_smu_outst),
    .trk_err(trk_err), .trk_ld_cnt(trk_ld_cnt), .trk_st_cnt(trk_st_cnt)
  );

`ifdef DCU_TRK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } comp_t;

  int          checks = 0;
  int          errors = 0;
  comp_t       exp_iu[$], exp_smu[$];
  logic [31:0] mf_iu[$], mf_smu[$];
  logic [3:0]  exp_err;
  logic [31:0] exp_ld, exp_st;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_iu.delete();
    exp_smu.delete();
    mf_iu.delete();
    mf_smu.delete();
    exp_err = 4'd0;
    exp_ld  = 32'd0;
    exp_st  = 32'd0;
  endtask

  task automatic do_reset();
    reset_l      = 1'b0;
    iu_inst_c    = 8'd0;
    smu_inst_c   = 4'd0;
    dcu_addr_c   = 32'd0;
    dcu_data     = 32'd0;
    iu_data_vld  = 1'b0;
    smu_data_vld = 1'b0;
    #2;
    check("reset_outputs",
          {trk_iu_vld, trk_smu_vld, trk_iu_addr, trk_smu_addr, trk_data,
           trk_iu_outst, trk_smu_outst, trk_err, trk_ld_cnt, trk_st_cnt}, '0);
    model_clear();
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  // One clock of stimulus; the model decides pops, pushes and error bits from its own queues.
  task automatic step(input logic [7:0] iu, input logic [3:0] smu, input logic [31:0] addr,
                      input logic iv, input logic sv, input logic [31:0] data);
    logic  ipop, spop;
    comp_t c;
    iu_inst_c    = iu;
    smu_inst_c   = smu;
    dcu_addr_c   = addr;
    iu_data_vld  = iv;
    smu_data_vld = sv;
    dcu_data     = data;
    ipop = iv && (mf_iu.size() > 0);
    spop = sv && (mf_smu.size() > 0);
    if (iv && !ipop) exp_err[1] = 1'b1;
    if (sv && !spop) exp_err[1] = 1'b1;
    if (iv && sv)    exp_err[2] = 1'b1;
    if (ipop) begin c.a = mf_iu.pop_front();  c.d = data; exp_iu.push_back(c);  end
    if (spop) begin c.a = mf_smu.pop_front(); c.d = data; exp_smu.push_back(c); end
    if (iu[2]) begin
      if (mf_iu.size() == 4) exp_err[0] = 1'b1;
      else mf_iu.push_back(addr);
    end
    if (smu[0]) begin
      if (mf_smu.size() == 4) exp_err[0] = 1'b1;
      else mf_smu.push_back(addr);
    end
    exp_ld = exp_ld + 32'(iu[2]) + 32'(smu[0]);
    exp_st = exp_st + 32'(iu[3]) + 32'(smu[1]);
    @(posedge clk);
    #1;
    iu_inst_c    = 8'd0;
    smu_inst_c   = 4'd0;
    iu_data_vld  = 1'b0;
    smu_data_vld = 1'b0;
    check("iu_vld",    trk_iu_vld,    ipop);
    check("smu_vld",   trk_smu_vld,   spop);
    check("iu_outst",  trk_iu_outst,  mf_iu.size());
    check("smu_outst", trk_smu_outst, mf_smu.size());
    check("err",       trk_err,       exp_err);
    check("ld_cnt",    trk_ld_cnt,    STATS ? exp_ld : 32'd0);
    check("st_cnt",    trk_st_cnt,    STATS ? exp_st : 32'd0);
  endtask

  always @(negedge clk) begin
    comp_t c;
    if (reset_l) begin
      if (trk_iu_vld && exp_iu.size() > 0) begin
        c = exp_iu.pop_front();
        check("iu_addr",  trk_iu_addr, c.a);
        check("iu_data",  trk_data,    c.d);
      end
      if (trk_smu_vld && exp_smu.size() > 0) begin
        c = exp_smu.pop_front();
        check("smu_addr", trk_smu_addr, c.a);
        check("smu_data", trk_data,     c.d);
      end
    end
  end

  initial begin
    do_reset();

    // Single IU load, returned five cycles later.
    step(8'h04, 4'h0, 32'h100, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(8'h00, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE);

    // Fill, push+pop at full, overflow, then drain in order across the pointer wrap.
    do_reset();
    for (int i = 1; i <= 4; i++) step(8'h04, 4'h0, 32'(i * 16), 1'b0, 1'b0, 32'h0);
    step(8'h04, 4'h0, 32'h50, 1'b1, 1'b0, 32'hA1);
    step(8'h04, 4'h0, 32'h60, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(8'h00, 4'h0, 32'h0, 1'b1, 1'b0, 32'hB0 + 32'(i));

    // Orphan SMU return alongside an SMU fill push, then the fill returns.
    do_reset();
    step(8'h00, 4'h1, 32'h200, 1'b0, 1'b1, 32'h11);
    step(8'h00, 4'h0, 32'h0,   1'b0, 1'b1, 32'h22);

    // Dual return: both sources complete with the same data word.
    do_reset();
    step(8'h04, 4'h0, 32'h300, 1'b0, 1'b0, 32'h0);
    step(8'h00, 4'h1, 32'h400, 1'b0, 1'b0, 32'h0);
    step(8'h00, 4'h0, 32'h0,   1'b1, 1'b1, 32'hD00D);

    // Timeout after eight cycles at the head, then reset with a load outstanding.
    do_reset();
    step(8'h04, 4'h0, 32'h500, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) step(8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_err[3] = 1'b1;
    step(8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_reset();
    step(8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Issue counters, including a combined load+store command.
    do_reset();
    for (int i = 0; i < 3; i++) step(8'h04, 4'h0, 32'h600 + 32'(i), 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(8'h00, 4'h2, 32'h700, 1'b0, 1'b0, 32'h0);
    step(8'h08, 4'h0, 32'h800, 1'b0, 1'b0, 32'h0);
    step(8'h0C, 4'h0, 32'h900, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    check("iu_scoreboard_drained",  exp_iu.size(),  0);
    check("smu_scoreboard_drained", exp_smu.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
